// File: rtl/snake_move_ctrl_if.sv
// Signal bundle between the snake move sequencer, the direction shift register,
// the game logic and the renderer.
interface snake_move_ctrl_if;
    logic       tick;
    logic [2:0] dir_in;
    logic       grow;
    logic       shift;
    logic [2:0] load;
    logic [5:0] pos;
    logic [2:0] out_pos;
    logic [5:0] head_x;
    logic [5:0] head_y;
    logic [6:0] length;
    logic       seg_valid;
    logic [5:0] seg_x;
    logic [5:0] seg_y;
    logic [5:0] seg_idx;
    logic       busy;
    logic       done;
    logic       self_hit;
    logic       overrun;

    modport master (
        input  tick, dir_in, grow, out_pos,
        output shift, load, pos, head_x, head_y, length,
               seg_valid, seg_x, seg_y, seg_idx, busy, done, self_hit, overrun
    );

    modport slave (
        output tick, dir_in, grow, out_pos,
        input  shift, load, pos, head_x, head_y, length,
               seg_valid, seg_x, seg_y, seg_idx, busy, done, self_hit, overrun
    );
endinterface

// File: rtl/snake_move_ctrl.sv
// Per-tick snake sequencer: filters heading, shifts the direction register,
// advances the head, then walks the body streaming segment coordinates.
module snake_move_ctrl #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int START_X  = 16,
    parameter int START_Y  = 12,
    parameter int INIT_LEN = 3
) (
    input  logic              clk,
    input  logic              reset,
    snake_move_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WALK  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] X_MAX   = 6'(GRID_W - 1);
    localparam logic [5:0] Y_MAX   = 6'(GRID_H - 1);
    localparam logic [6:0] LEN_MAX = 7'd64;

    state_t     state_r;
    logic       shift_r;
    logic [2:0] load_r;
    logic [5:0] pos_r;
    logic [2:0] heading_r;
    logic [5:0] head_x_r;
    logic [5:0] head_y_r;
    logic [6:0] length_r;
    logic       seg_valid_r;
    logic [5:0] seg_x_r;
    logic [5:0] seg_y_r;
    logic [5:0] seg_idx_r;
    logic       busy_r;
    logic       done_r;
    logic       self_hit_r;
    logic       overrun_r;
    logic       pend_tick_r;
    logic       pend_grow_r;
    logic       hit_acc_r;
    logic [6:0] widx_r;

    logic [2:0] heading_nxt_s;
    logic       start_s;
    logic       grow_now_s;
    logic [5:0] head_nx_s;
    logic [5:0] head_ny_s;
    logic [5:0] seg_nx_s;
    logic [5:0] seg_ny_s;

    function automatic logic [2:0] opposite(input logic [2:0] d);
        case (d)
            3'd1:    opposite = 3'd2;
            3'd2:    opposite = 3'd1;
            3'd3:    opposite = 3'd4;
            3'd4:    opposite = 3'd3;
            default: opposite = 3'd0;
        endcase
    endfunction

    // One toroidal grid step; codes outside 1..4 leave the cell unchanged.
    function automatic logic [11:0] step_xy(input logic [5:0] x, input logic [5:0] y,
                                            input logic [2:0] d);
        logic [5:0] nx;
        logic [5:0] ny;
        nx = x;
        ny = y;
        case (d)
            3'd1:    ny = (y == 6'd0)  ? Y_MAX : y - 6'd1;
            3'd2:    ny = (y == Y_MAX) ? 6'd0  : y + 6'd1;
            3'd3:    nx = (x == 6'd0)  ? X_MAX : x - 6'd1;
            3'd4:    nx = (x == X_MAX) ? 6'd0  : x + 6'd1;
            default: begin
                nx = x;
                ny = y;
            end
        endcase
        step_xy = {nx, ny};
    endfunction

    // Heading filter, acceptance terms and next head / next body coordinates.
    always_comb begin
        heading_nxt_s = heading_r;
        if ((bus.dir_in >= 3'd1) && (bus.dir_in <= 3'd4) &&
            (bus.dir_in != opposite(heading_r))) begin
            heading_nxt_s = bus.dir_in;
        end else begin
            heading_nxt_s = heading_r;
        end
        start_s    = bus.tick | pend_tick_r;
        grow_now_s = bus.grow | pend_grow_r;
        {head_nx_s, head_ny_s} = step_xy(head_x_r, head_y_r, heading_nxt_s);
        {seg_nx_s, seg_ny_s}   = step_xy(seg_x_r, seg_y_r, opposite(bus.out_pos));
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            shift_r     <= 1'b0;
            load_r      <= 3'd0;
            pos_r       <= 6'd0;
            heading_r   <= 3'd0;
            head_x_r    <= 6'(START_X);
            head_y_r    <= 6'(START_Y);
            length_r    <= 7'(INIT_LEN);
            seg_valid_r <= 1'b0;
            seg_x_r     <= 6'd0;
            seg_y_r     <= 6'd0;
            seg_idx_r   <= 6'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            self_hit_r  <= 1'b0;
            overrun_r   <= 1'b0;
            pend_tick_r <= 1'b0;
            pend_grow_r <= 1'b0;
            hit_acc_r   <= 1'b0;
            widx_r      <= 7'd0;
        end else begin
            shift_r     <= 1'b0;
            done_r      <= 1'b0;
            pend_grow_r <= grow_now_s;
            if ((state_r != ST_IDLE) && bus.tick) begin
                if (pend_tick_r) begin
                    overrun_r <= 1'b1;
                end else begin
                    pend_tick_r <= 1'b1;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        // A fresh tick arriving with a pending one keeps one queued.
                        pend_tick_r <= bus.tick & pend_tick_r;
                        if (heading_nxt_s != 3'd0) begin
                            state_r    <= ST_SHIFT;
                            busy_r     <= 1'b1;
                            shift_r    <= 1'b1;
                            load_r     <= heading_nxt_s;
                            heading_r  <= heading_nxt_s;
                            head_x_r   <= head_nx_s;
                            head_y_r   <= head_ny_s;
                            self_hit_r <= 1'b0;
                            hit_acc_r  <= 1'b0;
                            if (grow_now_s) begin
                                pend_grow_r <= 1'b0;
                                if (length_r != LEN_MAX) begin
                                    length_r <= length_r + 7'd1;
                                end
                            end
                        end
                    end
                end
                ST_SHIFT: begin
                    state_r <= ST_WALK;
                    pos_r   <= 6'd0;
                    widx_r  <= 7'd0;
                end
                ST_WALK: begin
                    if (widx_r == length_r) begin
                        state_r     <= ST_DONE;
                        seg_valid_r <= 1'b0;
                        done_r      <= 1'b1;
                        self_hit_r  <= hit_acc_r;
                    end else begin
                        seg_valid_r <= 1'b1;
                        seg_idx_r   <= widx_r[5:0];
                        widx_r      <= widx_r + 7'd1;
                        pos_r       <= (pos_r == 6'd63) ? 6'd63 : pos_r + 6'd1;
                        if (widx_r == 7'd0) begin
                            seg_x_r <= head_x_r;
                            seg_y_r <= head_y_r;
                        end else begin
                            seg_x_r <= seg_nx_s;
                            seg_y_r <= seg_ny_s;
                            // out_pos here is the direction read for the previous index.
                            if ((opposite(bus.out_pos) != 3'd0) &&
                                (seg_nx_s == head_x_r) && (seg_ny_s == head_y_r)) begin
                                hit_acc_r <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.shift     = shift_r;
    assign bus.load      = load_r;
    assign bus.pos       = pos_r;
    assign bus.head_x    = head_x_r;
    assign bus.head_y    = head_y_r;
    assign bus.length    = length_r;
    assign bus.seg_valid = seg_valid_r;
    assign bus.seg_x     = seg_x_r;
    assign bus.seg_y     = seg_y_r;
    assign bus.seg_idx   = seg_idx_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.self_hit  = self_hit_r;
    assign bus.overrun   = overrun_r;
endmodule
